uart_rx_ovs: RTL and testbench

UART_RX_OVS -- requirements
Module: uart_rx_ovs

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_sample_tick.sv | 28 ++
 rtl/uart_rx_ovs.sv | 178 +++++++++++++++++
 tb/tb_uart_rx_ovs.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the oversampling UART receiver.
// State encoding, parity modes and the parity check helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK_WAIT
  } rx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // xr is the XOR of the received data bits
  function automatic logic parity_err(
    input int   mode,
    input logic pbit,
    input logic xr
  );
    if (mode == PARITY_ODD) return pbit == xr;
    return pbit != xr;
  endfunction

endpackage

// File: rtl/uart_sample_tick.sv
// Free-running prescaler producing one sample tick
// every PRESCALE clocks.
module uart_sample_tick #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver with parity, stop-bit
// and break detection.
module uart_rx_ovs
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int OVERSAMPLE  = 16,
  parameter int PRESCALE    = 4
) (
  input  logic                 i_rx_clk,
  input  logic                 i_rx_rst,
  input  logic                 i_rx_serial,
  input  logic                 i_rx_enable,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_data_valid,
  output logic                 o_rx_parity_error,
  output logic                 o_rx_frame_error,
  output logic                 o_rx_break,
  output logic                 o_rx_busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(OVERSAMPLE - 1);
  localparam logic [3:0] DLAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] SLAST = 4'(STOP_BITS - 1);
  localparam bit HAS_PAR = (PARITY_MODE != PARITY_NONE);

  rx_state_t state, state_n;

  logic [1:0]           sync;
  logic                 rx_s;
  logic                 rx_q;
  logic                 fall;
  logic                 tick;
  logic                 samp;
  logic [CW-1:0]        cnt;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 stop_err;
  logic                 stop_one;
  logic                 brk_frame;
  logic                 fin;
  logic                 done;
  logic                 brk_hit;

  uart_sample_tick #(
    .PRESCALE(PRESCALE)
  ) u_tick (
    .clk  (i_rx_clk),
    .rst_n(i_rx_rst),
    .tick (tick)
  );

  assign rx_s = sync[1];
  assign fall = rx_q & ~rx_s;

  // all-zero frame including the stop sample now on the line
  assign brk_frame = (shreg == '0)
                   && (!HAS_PAR || !par_bit)
                   && !stop_one && !rx_s;

  always_comb begin
    samp = 1'b0;
    if (tick) begin
      unique case (state)
        ST_START:  samp = (cnt == HALF);
        ST_DATA,
        ST_PARITY,
        ST_STOP:   samp = (cnt == FULL);
        default:   samp = 1'b0;
      endcase
    end
  end

  always_ff @(posedge i_rx_clk or negedge i_rx_rst) begin
    if (!i_rx_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: begin
        if (i_rx_enable && fall) state_n = ST_START;
      end
      ST_START: begin
        if (!i_rx_enable) state_n = ST_IDLE;
        else if (samp)
          state_n = rx_s ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (!i_rx_enable) state_n = ST_IDLE;
        else if (samp && bit_idx == DLAST)
          state_n = HAS_PAR ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (!i_rx_enable) state_n = ST_IDLE;
        else if (samp) state_n = ST_STOP;
      end
      ST_STOP: begin
        if (!i_rx_enable) state_n = ST_IDLE;
        else if (samp && bit_idx == SLAST)
          state_n = brk_frame ? ST_BREAK_WAIT : ST_IDLE;
      end
      ST_BREAK_WAIT: begin
        if (!i_rx_enable || rx_s) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    o_rx_busy = (state != ST_IDLE);
    fin       = (state == ST_STOP) && i_rx_enable
              && samp && (bit_idx == SLAST);
    done      = fin && !brk_frame;
    brk_hit   = fin && brk_frame;
  end

  always_ff @(posedge i_rx_clk or negedge i_rx_rst) begin
    if (!i_rx_rst) begin
      sync              <= 2'b11;
      rx_q              <= 1'b1;
      cnt               <= '0;
      bit_idx           <= '0;
      shreg             <= '0;
      par_bit           <= 1'b0;
      stop_err          <= 1'b0;
      stop_one          <= 1'b0;
      o_rx_data         <= '0;
      o_rx_data_valid   <= 1'b0;
      o_rx_parity_error <= 1'b0;
      o_rx_frame_error  <= 1'b0;
      o_rx_break        <= 1'b0;
    end else begin
      sync            <= {sync[0], i_rx_serial};
      rx_q            <= rx_s;
      o_rx_data_valid <= done;
      o_rx_break      <= brk_hit;

      if (state == ST_IDLE || samp) cnt <= '0;
      else if (tick) cnt <= cnt + CW'(1);

      if (state_n != state) bit_idx <= '0;
      else if (samp) bit_idx <= bit_idx + 4'd1;

      if (state == ST_DATA && samp)
        shreg <= {rx_s, shreg[DATA_BITS-1:1]};

      if (state == ST_PARITY && samp)
        par_bit <= rx_s;

      if (state != ST_STOP) begin
        stop_err <= 1'b0;
        stop_one <= 1'b0;
      end else if (samp) begin
        stop_err <= stop_err | ~rx_s;
        stop_one <= stop_one | rx_s;
      end

      if (done) begin
        o_rx_data        <= shreg;
        o_rx_frame_error <= stop_err | ~rx_s;
        o_rx_parity_error <= HAS_PAR
          ? parity_err(PARITY_MODE, par_bit, ^shreg)
          : 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Directed bench: an 8N1 and an 8E1 receiver checked
// against a frame-level expectation queue.
module tb_uart_rx_ovs;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic ser0 = 1'b1;
  logic ser1 = 1'b1;

  logic [7:0] data0, data1;
  logic v0, v1, pe0, pe1, fe0, fe1;
  logic bk0, bk1, by0, by1;

  always #5 clk = ~clk;

  uart_rx_ovs u0 (
    .i_rx_clk         (clk),
    .i_rx_rst         (rst_n),
    .i_rx_serial      (ser0),
    .i_rx_enable      (en),
    .o_rx_data        (data0),
    .o_rx_data_valid  (v0),
    .o_rx_parity_error(pe0),
    .o_rx_frame_error (fe0),
    .o_rx_break       (bk0),
    .o_rx_busy        (by0)
  );

  uart_rx_ovs #(
    .PARITY_MODE(1)
  ) u1 (
    .i_rx_clk         (clk),
    .i_rx_rst         (rst_n),
    .i_rx_serial      (ser1),
    .i_rx_enable      (en),
    .o_rx_data        (data1),
    .o_rx_data_valid  (v1),
    .o_rx_parity_error(pe1),
    .o_rx_frame_error (fe1),
    .o_rx_break       (bk1),
    .o_rx_busy        (by1)
  );

  typedef struct {
    bit         brk;
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t h0, h1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h",
               name, act, req);
    end
  endtask

  // frame-level expectation: even parity counts ones
  function automatic exp_t model(input bit par,
                                 input logic [7:0] d,
                                 input logic p,
                                 input logic s);
    exp_t e;
    e.d   = d;
    e.fe  = !s;
    e.pe  = par ? ((($countones(d) + int'(p)) % 2) != 0)
                : 1'b0;
    e.brk = (d == 8'h00) && (!par || !p) && !s;
    return e;
  endfunction

  task automatic cmp(input int k, input logic v,
                     input logic bk, input logic [7:0] d,
                     input logic pe, input logic fe);
    exp_t e;
    exp_t h;
    bit have;
    have = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (have) e = (k == 0) ? q0[0] : q1[0];
    h = (k == 0) ? h0 : h1;
    if (v) begin
      chk($sformatf("valid%0d_expected", k),
          32'(have && !e.brk), 1);
      if (have && !e.brk) begin
        if (k == 0) void'(q0.pop_front());
        else void'(q1.pop_front());
        chk($sformatf("data%0d", k), d, e.d);
        chk($sformatf("perr%0d", k), pe, e.pe);
        chk($sformatf("ferr%0d", k), fe, e.fe);
        if (k == 0) h0 = e;
        else h1 = e;
      end
    end
    if (bk) begin
      chk($sformatf("break%0d_expected", k),
          32'(have && e.brk), 1);
      if (have && e.brk) begin
        if (k == 0) void'(q0.pop_front());
        else void'(q1.pop_front());
      end
      chk($sformatf("break%0d_data_hold", k), d, h.d);
      chk($sformatf("break%0d_ferr_hold", k), fe, h.fe);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      cmp(0, v0, bk0, data0, pe0, fe0);
      cmp(1, v1, bk1, data1, pe1, fe1);
    end
  end

  task automatic line(input int k, input logic b);
    if (k == 0) ser0 = b;
    else ser1 = b;
  endtask

  task automatic send(input int k, input logic [7:0] d,
                      input logic p, input logic s,
                      input int abort_bit);
    logic b[$];
    b.push_back(1'b0);
    for (int i = 0; i < 8; i++) b.push_back(d[i]);
    if (k == 1) b.push_back(p);
    b.push_back(s);
    if (abort_bit < 0) begin
      if (k == 0) q0.push_back(model(0, d, p, s));
      else q1.push_back(model(1, d, p, s));
    end
    foreach (b[i]) begin
      line(k, b[i]);
      repeat (32) @(negedge clk);
      if (i == 4)
        chk($sformatf("busy%0d_mid", k),
            (k == 0) ? by0 : by1, 1);
      if (i == abort_bit) en = 1'b0;
      repeat (32) @(negedge clk);
      if (i == abort_bit)
        chk("busy0_after_abort", by0, 0);
    end
    line(k, 1'b1);
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    chk("pending0", q0.size(), 0);
    chk("pending1", q1.size(), 0);
  endtask

  initial begin
    h0 = '{1'b0, 8'h00, 1'b0, 1'b0};
    h1 = h0;
    repeat (5) @(negedge clk);
    chk("rst_data0", data0, 0);
    chk("rst_valid0", v0, 0);
    chk("rst_perr0", pe0, 0);
    chk("rst_ferr0", fe0, 0);
    chk("rst_break0", bk0, 0);
    chk("rst_busy0", by0, 0);
    chk("rst_data1", data1, 0);
    rst_n = 1'b1;
    en = 1'b1;
    repeat (20) @(negedge clk);

    send(0, 8'hA5, 1'b0, 1'b1, -1);
    settle(100);
    chk("lit_a5_data", data0, 8'hA5);
    chk("lit_a5_perr", pe0, 0);
    chk("lit_a5_ferr", fe0, 0);

    send(1, 8'hA5, 1'b1, 1'b1, -1);
    settle(100);
    chk("lit_par_bad", pe1, 1);
    send(1, 8'hA5, 1'b0, 1'b1, -1);
    settle(100);
    chk("lit_par_good", pe1, 0);
    chk("lit_par_data", data1, 8'hA5);

    send(0, 8'h3C, 1'b0, 1'b0, -1);
    settle(100);
    chk("lit_3c_data", data0, 8'h3C);
    chk("lit_3c_ferr", fe0, 1);

    // short glitch: false start
    ser0 = 1'b0;
    repeat (10) @(negedge clk);
    chk("glitch_busy", by0, 1);
    repeat (10) @(negedge clk);
    ser0 = 1'b1;
    repeat (20) @(negedge clk);
    chk("glitch_idle", by0, 0);
    settle(100);

    // 12 bit times low
    q0.push_back('{1'b1, 8'h00, 1'b0, 1'b0});
    ser0 = 1'b0;
    repeat (12 * 64 - 10) @(negedge clk);
    chk("break_busy", by0, 1);
    repeat (10) @(negedge clk);
    ser0 = 1'b1;
    repeat (10) @(negedge clk);
    chk("break_released", by0, 0);
    settle(100);
    chk("lit_break_data", data0, 8'h3C);
    chk("lit_break_ferr", fe0, 1);

    send(0, 8'h81, 1'b0, 1'b1, -1);
    send(0, 8'h7E, 1'b0, 1'b1, -1);
    settle(100);
    chk("lit_b2b_data", data0, 8'h7E);
    chk("lit_b2b_ferr", fe0, 0);

    send(0, 8'h55, 1'b0, 1'b1, 4);
    repeat (64) @(negedge clk);
    en = 1'b1;
    repeat (64) @(negedge clk);
    send(0, 8'h0F, 1'b0, 1'b1, -1);
    settle(100);
    chk("lit_abort_data", data0, 8'h0F);

    send(1, 8'h00, 1'b0, 1'b0, -1);
    settle(100);
    chk("lit_pbreak_hold", data1, 8'hA5);
    send(1, 8'h00, 1'b1, 1'b0, -1);
    settle(100);
    chk("lit_zero_perr", pe1, 1);
    chk("lit_zero_ferr", fe1, 1);
    chk("lit_zero_data", data1, 8'h00);

    // reset in the middle of a frame
    ser0 = 1'b0;
    repeat (3 * 64) @(negedge clk);
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    h0 = '{1'b0, 8'h00, 1'b0, 1'b0};
    h1 = h0;
    repeat (5) @(negedge clk);
    chk("midrst_busy", by0, 0);
    chk("midrst_data", data0, 0);
    ser0 = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    settle(300);
    chk("midrst_after", data0, 0);
    chk("midrst_idle", by0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
